// File: rtl/tile_pkg.sv
// tile_pkg: opcodes, screen geometry and FSM state types shared by the UART
// command front-end and the tile screen generator.
package tile_pkg;
    localparam logic [7:0] OP_RIGHT = 8'h72;
    localparam logic [7:0] OP_DOWN  = 8'h64;
    localparam logic [7:0] OP_PAT   = 8'h70;
    localparam logic [7:0] OP_WRITE = 8'h77;
    localparam logic [7:0] ROWS = 8'd8;
    localparam logic [7:0] COLS = 8'd80;
    localparam logic [7:0] PATS = 8'd4;
    localparam int ROW_W  = 3;
    localparam int COL_W  = 7;
    localparam int ADDR_W = ROW_W + COL_W;
    typedef enum logic [1:0] {WAIT_OP, GET_ROW, GET_COL, GET_PAT} parse_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
endpackage

// File: rtl/uart_tile_cmd_if.sv
// uart_tile_cmd_if: decoded command strobes, tile write port and raw byte status.
interface uart_tile_cmd_if;
    import tile_pkg::*;
    logic              right_tick;
    logic              down_tick;
    logic              pattern_tick;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [2:0]        wr_data;
    logic              rx_valid;
    logic [7:0]        rx_byte;
    logic              frame_err;
    logic              cmd_err;
    modport master (output right_tick, down_tick, pattern_tick, wr_en, wr_addr, wr_data,
                    rx_valid, rx_byte, frame_err, cmd_err);
    modport slave  (input  right_tick, down_tick, pattern_tick, wr_en, wr_addr, wr_data,
                    rx_valid, rx_byte, frame_err, cmd_err);
endinterface

// File: rtl/uart_rx_os.sv
// uart_rx_os: 8N1 receiver with 2-flop rx synchronizer and OVS-times oversampling.
module uart_rx_os import tile_pkg::*; #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 19200,
    parameter int OVS    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       s_tick,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);
    localparam int DIV = CLK_HZ / (BAUD * OVS);
    localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;
    localparam int NW  = $clog2(OVS);

    logic [1:0]    sync_q;
    logic [DW-1:0] div_q, div_d;
    rx_state_e     st_q, st_d;
    logic [NW-1:0] n_q, n_d;
    logic [2:0]    b_q, b_d;
    logic [7:0]    sh_q, sh_d, byte_q, byte_d;
    logic          valid_q, valid_d, ferr_q, ferr_d;
    logic          rx_s;

    assign rx_s      = sync_q[1];
    assign s_tick    = div_q == DW'(DIV - 1);
    assign div_d     = s_tick ? '0 : div_q + DW'(1);
    assign rx_valid  = valid_q;
    assign rx_byte   = byte_q;
    assign frame_err = ferr_q;

    always_comb begin
        st_d    = st_q;
        n_d     = n_q;
        b_d     = b_q;
        sh_d    = sh_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        if (s_tick) begin
            case (st_q)
                RX_IDLE: begin
                    st_d = rx_s ? RX_IDLE : RX_START;
                    n_d  = '0;
                end
                // mid start bit: a line already back high was only a glitch
                RX_START: begin
                    n_d = n_q + NW'(1);
                    if (n_q == NW'(OVS / 2 - 1)) begin
                        st_d = rx_s ? RX_IDLE : RX_DATA;
                        n_d  = '0;
                        b_d  = '0;
                    end
                end
                RX_DATA: begin
                    n_d = n_q + NW'(1);
                    if (n_q == NW'(OVS - 1)) begin
                        sh_d = {rx_s, sh_q[7:1]};
                        b_d  = b_q + 3'd1;
                        st_d = b_q == 3'd7 ? RX_STOP : RX_DATA;
                    end
                end
                default: begin
                    n_d = n_q + NW'(1);
                    if (n_q == NW'(OVS - 1)) begin
                        st_d    = RX_IDLE;
                        valid_d = rx_s;
                        ferr_d  = !rx_s;
                        byte_d  = rx_s ? sh_q : byte_q;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            div_q   <= '0;
            st_q    <= RX_IDLE;
            n_q     <= '0;
            b_q     <= '0;
            sh_q    <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx};
            div_q   <= div_d;
            st_q    <= st_d;
            n_q     <= n_d;
            b_q     <= b_d;
            sh_q    <= sh_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end
endmodule

// File: rtl/uart_tile_cmd.sv
// uart_tile_cmd: decodes UART bytes into cursor/pattern ticks and tile RAM writes.
// Optional UART_TILE_TIMEOUT_EN aborts a stalled 'w' packet after TIMEOUT_BITS bit-times.
module uart_tile_cmd import tile_pkg::*; #(
    parameter int CLK_HZ       = 50000000,
    parameter int BAUD         = 19200,
    parameter int OVS          = 16,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    uart_tile_cmd_if.master cmd
);
    logic         s_tick, rx_valid, frame_err;
    logic [7:0]   rx_byte;
    parse_state_e state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic              bad_q, bad_d, bad_now;
    logic              right_q, right_d, down_q, down_d, pat_q, pat_d;
    logic              wr_en_q, wr_en_d, cmd_err_q, cmd_err_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [2:0]        wr_data_q, wr_data_d;

    uart_rx_os #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVS(OVS)) u_rx (
        .clk(clk), .rst_n(rst_n), .rx(rx), .s_tick(s_tick),
        .rx_valid(rx_valid), .rx_byte(rx_byte), .frame_err(frame_err)
    );

    assign cmd.right_tick   = right_q;
    assign cmd.down_tick    = down_q;
    assign cmd.pattern_tick = pat_q;
    assign cmd.wr_en        = wr_en_q;
    assign cmd.wr_addr      = wr_addr_q;
    assign cmd.wr_data      = wr_data_q;
    assign cmd.cmd_err      = cmd_err_q;
    assign cmd.rx_valid     = rx_valid;
    assign cmd.rx_byte      = rx_byte;
    assign cmd.frame_err    = frame_err;

`ifdef UART_TILE_TIMEOUT_EN
    localparam int TO_LIMIT = TIMEOUT_BITS * OVS;
    localparam int TW = $clog2(TO_LIMIT + 1);
    logic [TW-1:0] idle_q, idle_d;
    assign idle_d = (state_q == WAIT_OP || rx_valid) ? '0 : idle_q + TW'(s_tick);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idle_q <= '0;
        else        idle_q <= idle_d;
    end
`else
    logic unused_sig;
    assign unused_sig = s_tick & (TIMEOUT_BITS > 0);
`endif

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        bad_d     = bad_q;
        bad_now   = 1'b0;
        right_d   = 1'b0;
        down_d    = 1'b0;
        pat_d     = 1'b0;
        wr_en_d   = 1'b0;
        cmd_err_d = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (rx_valid) begin
            case (state_q)
                WAIT_OP: begin
                    right_d   = rx_byte == OP_RIGHT;
                    down_d    = rx_byte == OP_DOWN;
                    pat_d     = rx_byte == OP_PAT;
                    state_d   = rx_byte == OP_WRITE ? GET_ROW : WAIT_OP;
                    cmd_err_d = !(right_d || down_d || pat_d || rx_byte == OP_WRITE);
                end
                GET_ROW: begin
                    row_d   = rx_byte[ROW_W-1:0];
                    bad_d   = bad_q | (rx_byte >= ROWS);
                    state_d = GET_COL;
                end
                GET_COL: begin
                    col_d   = rx_byte[COL_W-1:0];
                    bad_d   = bad_q | (rx_byte >= COLS);
                    state_d = GET_PAT;
                end
                default: begin
                    bad_now   = bad_q | (rx_byte >= PATS);
                    wr_en_d   = !bad_now;
                    cmd_err_d = bad_now;
                    wr_addr_d = bad_now ? wr_addr_q : {row_q, col_q};
                    wr_data_d = bad_now ? wr_data_q : {1'b1, rx_byte[1:0]};
                    bad_d     = 1'b0;
                    state_d   = WAIT_OP;
                end
            endcase
        end
`ifdef UART_TILE_TIMEOUT_EN
        else if (state_q != WAIT_OP && idle_q == TW'(TO_LIMIT)) begin
            state_d   = WAIT_OP;
            bad_d     = 1'b0;
            cmd_err_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WAIT_OP;
            row_q     <= '0;
            col_q     <= '0;
            bad_q     <= 1'b0;
            right_q   <= 1'b0;
            down_q    <= 1'b0;
            pat_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            cmd_err_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            bad_q     <= bad_d;
            right_q   <= right_d;
            down_q    <= down_d;
            pat_q     <= pat_d;
            wr_en_q   <= wr_en_d;
            cmd_err_q <= cmd_err_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end
endmodule

// File: tb/tb_uart_tile_cmd.sv
// tb_uart_tile_cmd: directed byte sequences with hand-computed pulse counts and write fields.
// Clock chosen so the oversample divider is 2 (32 clk per bit) to keep runs short.
module tb_uart_tile_cmd;
    localparam int CLK_HZ = 614400;
    localparam int BAUD   = 19200;
    localparam int OVS    = 16;
    localparam int BIT    = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;
    uart_tile_cmd_if cmd_if();

    uart_tile_cmd #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVS(OVS), .TIMEOUT_BITS(64)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .cmd(cmd_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, last_v = -100;
    int n_valid = 0, n_right = 0, n_down = 0, n_pat = 0, n_wr = 0, n_cerr = 0, n_ferr = 0;
    int n_lat = 0, n_multi = 0;
    logic [11:0] seq = '0;
    logic to_win = 1'b0;
    int b_valid, b_right, b_down, b_pat, b_wr, b_cerr, b_ferr;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (cmd_if.rx_valid) begin n_valid++; last_v = cyc; end
        if (cmd_if.right_tick)   begin n_right++; seq = {seq[9:0], 2'd1}; end
        if (cmd_if.down_tick)    begin n_down++;  seq = {seq[9:0], 2'd2}; end
        if (cmd_if.pattern_tick) begin n_pat++;   seq = {seq[9:0], 2'd3}; end
        if (cmd_if.wr_en)     n_wr++;
        if (cmd_if.cmd_err)   n_cerr++;
        if (cmd_if.frame_err) n_ferr++;
        if ((cmd_if.right_tick | cmd_if.down_tick | cmd_if.pattern_tick | cmd_if.wr_en |
             (cmd_if.cmd_err & !to_win)) && (cyc - last_v != 1)) n_lat++;
        if ($countones({cmd_if.right_tick, cmd_if.down_tick, cmd_if.pattern_tick,
                        cmd_if.wr_en, cmd_if.cmd_err}) > 1) n_multi++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_valid = n_valid; b_right = n_right; b_down = n_down; b_pat = n_pat;
        b_wr = n_wr; b_cerr = n_cerr; b_ferr = n_ferr;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (BIT) @(posedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", {cmd_if.right_tick, cmd_if.down_tick, cmd_if.pattern_tick,
              cmd_if.wr_en, cmd_if.wr_addr, cmd_if.wr_data, cmd_if.rx_valid, cmd_if.rx_byte,
              cmd_if.frame_err, cmd_if.cmd_err}, 0);
        @(posedge clk);
        rst_n = 1'b1;
        idle(40);

        snap();
        send_byte(8'h72, 1'b1); send_byte(8'h64, 1'b1); send_byte(8'h70, 1'b1);
        idle(40);
        check("tick_right", n_right - b_right, 1);
        check("tick_down", n_down - b_down, 1);
        check("tick_pat", n_pat - b_pat, 1);
        check("tick_order", seq[5:0], 6'b01_10_11);
        check("tick_no_cerr", n_cerr - b_cerr, 0);

        snap();
        send_byte(8'h77, 1'b1); send_byte(8'h03, 1'b1); send_byte(8'h4F, 1'b1); send_byte(8'h02, 1'b1);
        idle(40);
        check("wr1_count", n_wr - b_wr, 1);
        check("wr1_addr", cmd_if.wr_addr, 10'b011_1001111);
        check("wr1_data", cmd_if.wr_data, 3'b110);
        check("wr1_no_cerr", n_cerr - b_cerr, 0);
        check("wr1_rx_byte", cmd_if.rx_byte, 8'h02);

        snap();
        send_byte(8'h77, 1'b1); send_byte(8'h07, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h03, 1'b1);
        idle(40);
        check("wr2_count", n_wr - b_wr, 1);
        check("wr2_addr", cmd_if.wr_addr, 10'b111_0000000);
        check("wr2_data", cmd_if.wr_data, 3'b111);

        snap();
        send_byte(8'h77, 1'b1); send_byte(8'h03, 1'b1); send_byte(8'h50, 1'b1); send_byte(8'h02, 1'b1);
        idle(40);
        check("col80_no_wr", n_wr - b_wr, 0);
        check("col80_cerr", n_cerr - b_cerr, 1);
        check("col80_addr_held", cmd_if.wr_addr, 10'b111_0000000);
        snap();
        send_byte(8'h72, 1'b1);
        idle(40);
        check("col80_then_right", n_right - b_right, 1);

        snap();
        send_byte(8'h77, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h72, 1'b1); send_byte(8'h00, 1'b1);
        idle(40);
        check("opdata_no_right", n_right - b_right, 0);
        check("opdata_cerr", n_cerr - b_cerr, 1);
        check("opdata_no_wr", n_wr - b_wr, 0);

        snap();
        send_byte(8'h41, 1'b1);
        idle(40);
        check("unknown_cerr", n_cerr - b_cerr, 1);

        snap();
        send_byte(8'h55, 1'b0);
        idle(64);
        check("ferr_pulse", n_ferr - b_ferr, 1);
        check("ferr_no_valid", n_valid - b_valid, 0);
        snap();
        send_byte(8'h72, 1'b1);
        idle(40);
        check("ferr_then_right", n_right - b_right, 1);
        check("ferr_then_valid", n_valid - b_valid, 1);

        snap();
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(400);
        check("glitch_no_valid", n_valid - b_valid, 0);
        check("glitch_no_ferr", n_ferr - b_ferr, 0);
        send_byte(8'h70, 1'b1);
        idle(40);
        check("glitch_then_pat", n_pat - b_pat, 1);

        snap();
        send_byte(8'h77, 1'b1); send_byte(8'h01, 1'b1);
        to_win = 1'b1;
        idle(1900);
        check("timeout_early", n_cerr - b_cerr, 0);
        idle(400);
`ifdef UART_TILE_TIMEOUT_EN
        check("timeout_cerr", n_cerr - b_cerr, 1);
        to_win = 1'b0;
        snap();
        send_byte(8'h64, 1'b1);
        idle(40);
        check("timeout_then_down", n_down - b_down, 1);
`else
        check("no_timeout_cerr", n_cerr - b_cerr, 0);
        to_win = 1'b0;
        snap();
        send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        idle(40);
        check("stall_finish_wr", n_wr - b_wr, 1);
        check("stall_finish_addr", cmd_if.wr_addr, 10'b001_0000000);
        check("stall_finish_data", cmd_if.wr_data, 3'b100);
`endif

        snap();
        send_byte(8'h77, 1'b1); send_byte(8'h02, 1'b1);
        rx = 1'b0;
        idle(BIT);
        rx = 1'b0;
        idle(BIT + 10);
        rx = 1'b1;
        rst_n = 1'b0;
        idle(3);
        @(negedge clk);
        check("rst_mid_outputs", {cmd_if.right_tick, cmd_if.down_tick, cmd_if.pattern_tick,
              cmd_if.wr_en, cmd_if.wr_addr, cmd_if.wr_data, cmd_if.rx_valid, cmd_if.rx_byte,
              cmd_if.frame_err, cmd_if.cmd_err}, 0);
        @(posedge clk);
        rst_n = 1'b1;
        idle(400);
        check("rst_no_pulses", (n_valid - b_valid - 2) + (n_right - b_right) + (n_down - b_down) +
              (n_pat - b_pat) + (n_wr - b_wr) + (n_cerr - b_cerr) + (n_ferr - b_ferr), 0);
        snap();
        send_byte(8'h72, 1'b1);
        idle(40);
        check("rst_then_right", n_right - b_right, 1);
        check("rst_then_no_wr", n_wr - b_wr, 0);

        check("latency_1clk", n_lat, 0);
        check("one_hot_outputs", n_multi, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
